// File: rtl/swan_pkg.sv
// swan_pkg: shared definitions for the SWAN128 stream adapter.
//   SWAN_BLOCK_W : default cipher block width
//   swan_state_t : adapter FSM state encoding
//   swan_cnt_w() : width of a word counter for a given words-per-block
package swan_pkg;

  localparam int SWAN_BLOCK_W = 128;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    KICK  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } swan_state_t;

  // Never returns 0, so a degenerate single-word block still gets a 1-bit counter.
  function automatic int swan_cnt_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/swan_word_serializer.sv
// swan_word_serializer: holds one cipher output block and emits it as
// WORDS stream words, word 0 (block MSBs) first.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   load           capture load_data and start emitting
//   load_data      block to emit, bit 0 = MSB
//   m_valid/ready  output stream handshake, m_data = current word
//   last_beat      final word handshakes this cycle
module swan_word_serializer
  import swan_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int BLOCK_W = SWAN_BLOCK_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [0:BLOCK_W-1] load_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WORD_W-1:0]  m_data,
  output logic               last_beat
);

  localparam int WORDS = BLOCK_W / WORD_W;
  localparam int CW    = swan_cnt_w(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  logic [0:BLOCK_W-1] out_reg;
  logic [CW-1:0]      idx;

  assign last_beat = m_valid && m_ready && (idx == LAST);

  // Constant-index mux keeps the select free of variable part-select widths.
  always_comb begin
    m_data = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx == CW'(k)) m_data = out_reg[k*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_reg <= '0;
      idx     <= '0;
      m_valid <= 1'b0;
    end else if (load) begin
      out_reg <= load_data;
      idx     <= '0;
      m_valid <= 1'b1;
    end else if (m_valid && m_ready) begin
      if (idx == LAST) begin
        m_valid <= 1'b0;
        idx     <= '0;
      end else begin
        idx <= idx + CW'(1);
      end
    end
  end

endmodule

// File: rtl/swan128_stream_adapter.sv
// swan128_stream_adapter: packs WORD_W plaintext words into a BLOCK_W block,
// runs it through a serial SWAN128 core and streams the ciphertext back out.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   s_valid/s_ready/s_data   plaintext word stream in
//   m_valid/m_ready/m_data   ciphertext word stream out
//   core_start/core_inp      one-cycle kick and block to the core
//   core_ready/core_out      core completion and result
//   busy                     high unless idle in LOAD with no words taken
//   iv, iv_load              CBC chaining seed (only with SWAN128_ADAPTER_CBC_EN)
// Build option: define SWAN128_ADAPTER_CBC_EN for CBC chaining; default is ECB.
//
// state | meaning
// LOAD  | accepting plaintext words 0..WORDS-1
// KICK  | single-cycle core_start pulse
// WAIT  | core running; core_ready ignored on the first cycle
// DRAIN | emitting ciphertext words
module swan128_stream_adapter
  import swan_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int BLOCK_W = SWAN_BLOCK_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WORD_W-1:0]  s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WORD_W-1:0]  m_data,
  output logic               core_start,
  output logic [0:BLOCK_W-1] core_inp,
  input  logic               core_ready,
  input  logic [0:BLOCK_W-1] core_out,
`ifdef SWAN128_ADAPTER_CBC_EN
  input  logic [0:BLOCK_W-1] iv,
  input  logic               iv_load,
`endif
  output logic               busy
);

  localparam int WORDS = BLOCK_W / WORD_W;
  localparam int CW    = swan_cnt_w(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  swan_state_t        state;
  logic [CW-1:0]      in_cnt;
  logic [0:BLOCK_W-1] blk;
  logic [0:BLOCK_W-1] blk_nxt;
  logic [0:BLOCK_W-1] inp_nxt;
  logic               wait_first;
  logic               s_accept;
  logic               capture;
  logic               last_beat;

  assign s_accept = s_valid && s_ready;
  assign capture  = (state == WAIT) && !wait_first && core_ready;

  // Block with this cycle's word merged in, so the core input can be
  // registered on the same edge that accepts the final word.
  always_comb begin
    blk_nxt = blk;
    for (int k = 0; k < WORDS; k++) begin
      if (s_accept && (in_cnt == CW'(k))) blk_nxt[k*WORD_W +: WORD_W] = s_data;
    end
  end

`ifdef SWAN128_ADAPTER_CBC_EN
  logic [0:BLOCK_W-1] chain;

  assign inp_nxt = blk_nxt ^ chain;

  always_ff @(posedge clk) begin
    if (!rst) begin
      chain <= '0;
    end else if (capture) begin
      chain <= core_out;
    end else if ((state == LOAD) && (in_cnt == '0) && iv_load) begin
      chain <= iv;
    end
  end
`else
  assign inp_nxt = blk_nxt;
`endif

  // core_inp is a register loaded once per block, so it stays put through
  // WAIT and DRAIN even when the chain register moves on capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= LOAD;
      in_cnt     <= '0;
      blk        <= '0;
      core_inp   <= '0;
      s_ready    <= 1'b1;
      core_start <= 1'b0;
      busy       <= 1'b0;
      wait_first <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        LOAD: begin
          if (s_accept) begin
            blk  <= blk_nxt;
            busy <= 1'b1;
            if (in_cnt == LAST) begin
              core_inp   <= inp_nxt;
              in_cnt     <= '0;
              s_ready    <= 1'b0;
              core_start <= 1'b1;
              state      <= KICK;
            end else begin
              in_cnt <= in_cnt + CW'(1);
            end
          end
        end
        KICK: begin
          wait_first <= 1'b1;
          state      <= WAIT;
        end
        WAIT: begin
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (core_ready) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_beat) begin
            state   <= LOAD;
            s_ready <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  swan_word_serializer #(
    .WORD_W  (WORD_W),
    .BLOCK_W (BLOCK_W)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (capture),
    .load_data (core_out),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .last_beat (last_beat)
  );

endmodule

// File: tb/tb_swan128_stream_adapter.sv
// Bench for swan128_stream_adapter (32-bit words, 128-bit block).
// The core stub raises ready 130 cycles after start with out = inp XOR ones.
// Define SWAN128_ADAPTER_CBC_EN to exercise the CBC build.
`timescale 1ns/1ps
module tb_swan128_stream_adapter;

  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 128;
  localparam int WORDS   = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [WORD_W-1:0]  s_data = '0;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic [WORD_W-1:0]  m_data;
  logic               core_start;
  logic [0:BLOCK_W-1] core_inp;
  logic               core_ready = 1'b0;
  logic [0:BLOCK_W-1] core_out = '0;
  logic               busy;
`ifdef SWAN128_ADAPTER_CBC_EN
  logic [0:BLOCK_W-1] iv = '0;
  logic               iv_load = 1'b1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  swan128_stream_adapter #(.WORD_W(WORD_W), .BLOCK_W(BLOCK_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .core_start (core_start),
    .core_inp   (core_inp),
    .core_ready (core_ready),
    .core_out   (core_out),
`ifdef SWAN128_ADAPTER_CBC_EN
    .iv         (iv),
    .iv_load    (iv_load),
`endif
    .busy       (busy)
  );

  // Core stub: independent of the adapter reset, so a reset mid-run still
  // sees a late core_ready.
  int stub_cnt = 0;
  always @(posedge clk) begin
    if (core_start) begin
      stub_cnt   <= 130;
      core_ready <= 1'b0;
      core_out   <= ~core_inp;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) core_ready <= 1'b1;
    end
  end

  // Monitor, sampled on the falling edge.
  logic [0:BLOCK_W-1] q_start[$];
  logic [WORD_W-1:0]  q_out[$];
  logic               prev_start = 1'b0;
  logic               hold_pend = 1'b0;
  logic [WORD_W-1:0]  hold_data = '0;
  int dbl_start = 0;
  int hold_err  = 0;
  int mv_cnt    = 0;
  int acc_cnt   = 0;

  always @(negedge clk) begin
    if (core_start) begin
      q_start.push_back(core_inp);
      if (prev_start) dbl_start <= dbl_start + 1;
    end
    prev_start <= core_start;
    if (m_valid && m_ready) q_out.push_back(m_data);
    if (m_valid) mv_cnt <= mv_cnt + 1;
    if (hold_pend && m_valid && (m_data !== hold_data)) hold_err <= hold_err + 1;
    hold_pend <= m_valid && !m_ready;
    hold_data <= m_data;
    if (s_valid && s_ready) acc_cnt <= acc_cnt + 1;
  end

  // Reference model: word j of a block is its j-th 32-bit field from the top.
  function automatic logic [WORD_W-1:0] word_of(input logic [BLOCK_W-1:0] b, input int j);
    return b[BLOCK_W-1-WORD_W*j -: WORD_W];
  endfunction

  function automatic logic [BLOCK_W-1:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_words(input logic [BLOCK_W-1:0] b, input int first, input bit gaps);
    bit acc;
    int guard;
    for (int k = first; k < WORDS; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          s_valid = 1'b0;
          s_data  = $urandom;
          @(posedge clk); #1;
        end
      end
      s_valid = 1'b1;
      s_data  = word_of(b, k);
      guard   = 0;
      do begin
        acc = s_ready;
        @(posedge clk); #1;
        guard++;
      end while (!acc && guard < 400);
      if (!acc) begin
        n_tests++; n_fail++;
        $display("FAIL send_timeout: word %0d not accepted, s_ready=%b required 1", k, s_ready);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget);
    int g = 0;
    while (q_start.size() < n && g < budget) begin
      @(posedge clk); #1;
      g++;
    end
    if (q_start.size() < n) begin
      n_tests++; n_fail++;
      $display("FAIL start_timeout: got %0d starts required %0d", q_start.size(), n);
    end
  endtask

  task automatic wait_mvalid();
    int g = 0;
    while (!m_valid && g < 400) begin
      @(posedge clk); #1;
      g++;
    end
    if (!m_valid) begin
      n_tests++; n_fail++;
      $display("FAIL mvalid_timeout: m_valid=%b required 1", m_valid);
    end
  endtask

  task automatic drain(input int n, input bit rnd);
    int g = 0;
    while (q_out.size() < n && g < 2000) begin
      m_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk); #1;
      g++;
    end
    m_ready = 1'b0;
    if (q_out.size() < n) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got %0d words required %0d", q_out.size(), n);
    end
  endtask

  task automatic check_block(input string tag, input logic [BLOCK_W-1:0] exp_inp);
    logic [BLOCK_W-1:0] exp_out;
    exp_out = ~exp_inp;
    n_tests++;
    if (q_start.size() < 1 || q_start[0] !== exp_inp) begin
      n_fail++;
      $display("FAIL %s core_inp: got %h required %h", tag,
               (q_start.size() > 0) ? q_start[0] : '0, exp_inp);
    end
    for (int j = 0; j < WORDS; j++) begin
      n_tests++;
      if (q_out.size() <= j || q_out[j] !== word_of(exp_out, j)) begin
        n_fail++;
        $display("FAIL %s m_data[%0d]: got %h required %h", tag, j,
                 (q_out.size() > j) ? q_out[j] : '0, word_of(exp_out, j));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b required 1", s_ready); end
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b required 0", m_valid); end
    n_tests++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL reset_core_start: got %b required 0", core_start); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_tests++; if (core_inp !== '0) begin n_fail++; $display("FAIL reset_core_inp: got %h required 0", core_inp); end
    n_tests++; if (m_data !== '0) begin n_fail++; $display("FAIL reset_m_data: got %h required 0", m_data); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [BLOCK_W-1:0] b;
    b = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    q_start.delete(); q_out.delete();
    send_words(b, 0, 1'b0);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL dir_busy_kick: got %b required 1", busy); end
    wait_starts(1, 20);
    repeat (60) @(posedge clk);
    #1;
    n_tests++; if (core_inp !== b) begin n_fail++; $display("FAIL dir_inp_hold: got %h required %h", core_inp, b); end
    n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL dir_s_ready_wait: got %b required 0", s_ready); end
    drain(WORDS, 1'b0);
    check_block("dir", b);
    n_tests++; if (q_out.size() > 1 && q_out[1] !== 32'hfbfaf9f8) begin n_fail++; $display("FAIL dir_word1: got %h required fbfaf9f8", q_out[1]); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dir_busy_end: got %b required 0", busy); end
    n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL dir_s_ready_end: got %b required 1", s_ready); end
    n_tests++; if (dbl_start !== 0) begin n_fail++; $display("FAIL dir_double_start: got %0d required 0", dbl_start); end
  endtask

  task automatic test_backpressure();
    logic [BLOCK_W-1:0] b;
    b = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    q_start.delete(); q_out.delete();
    send_words(b, 0, 1'b1);
    wait_mvalid();
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      n_tests++;
      if (m_valid !== 1'b1 || m_data !== 32'hfbfaf9f8) begin
        n_fail++;
        $display("FAIL bp_hold: got valid=%b data=%h required valid=1 data=fbfaf9f8", m_valid, m_data);
      end
    end
    @(posedge clk); #1;
    drain(WORDS, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    n_tests++; if (q_out.size() != WORDS) begin n_fail++; $display("FAIL bp_count: got %0d words required %0d", q_out.size(), WORDS); end
    check_block("bp", b);
  endtask

  task automatic test_svalid_during_drain();
    logic [BLOCK_W-1:0] a, b;
    int acc0;
    a = rand_block();
    b = rand_block();
    q_start.delete(); q_out.delete();
    send_words(a, 0, 1'b1);
    s_valid = 1'b1;
    s_data  = word_of(b, 0);
    acc0 = acc_cnt;
    wait_mvalid();
    drain(WORDS, 1'b1);
    n_tests++; if (acc_cnt !== acc0) begin n_fail++; $display("FAIL sv_no_accept: got %0d accepts required %0d", acc_cnt - acc0, 0); end
    check_block("sv_a", a);
    n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL sv_s_ready_load: got %b required 1", s_ready); end
    q_start.delete(); q_out.delete();
    @(posedge clk); #1;
    n_tests++; if (acc_cnt !== acc0 + 1) begin n_fail++; $display("FAIL sv_first_accept: got %0d accepts required 1", acc_cnt - acc0); end
    send_words(b, 1, 1'b1);
    wait_starts(1, 20);
    drain(WORDS, 1'b1);
    check_block("sv_b", b);
  endtask

  task automatic test_reset_mid_wait();
    int mv0;
    q_start.delete(); q_out.delete();
    send_words(rand_block(), 0, 1'b1);
    wait_starts(1, 20);
    repeat (49) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rw_s_ready: got %b required 1", s_ready); end
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rw_m_valid: got %b required 0", m_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rw_busy: got %b required 0", busy); end
    n_tests++; if (core_inp !== '0) begin n_fail++; $display("FAIL rw_core_inp: got %h required 0", core_inp); end
    mv0 = mv_cnt;
    m_ready = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    m_ready = 1'b0;
    n_tests++; if (mv_cnt !== mv0) begin n_fail++; $display("FAIL rw_late_ready: got %0d m_valid cycles required 0", mv_cnt - mv0); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rw_idle: got busy=%b required 0", busy); end
  endtask

  task automatic test_random();
    logic [BLOCK_W-1:0] b;
    for (int i = 0; i < 5; i++) begin
      b = rand_block();
      q_start.delete(); q_out.delete();
      send_words(b, 0, 1'b1);
      wait_starts(1, 20);
      drain(WORDS, 1'b1);
      check_block("rnd", b);
    end
    n_tests++; if (hold_err !== 0) begin n_fail++; $display("FAIL rnd_hold: got %0d unstable words required 0", hold_err); end
    n_tests++; if (dbl_start !== 0) begin n_fail++; $display("FAIL rnd_double_start: got %0d required 0", dbl_start); end
  endtask

`ifdef SWAN128_ADAPTER_CBC_EN
  task automatic test_cbc();
    logic [BLOCK_W-1:0] ones;
    ones = '1;
    iv = ones;
    iv_load = 1'b1;
    for (int i = 0; i < 2; i++) begin
      q_start.delete(); q_out.delete();
      send_words('0, 0, 1'b1);
      wait_starts(1, 20);
      drain(WORDS, 1'b1);
      check_block("cbc", ones);
    end
    iv = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_svalid_during_drain();
    test_reset_mid_wait();
    test_random();
`ifdef SWAN128_ADAPTER_CBC_EN
    test_cbc();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
